// File: rtl/fp_sub_seq_pkg.sv
// Shared definitions for the sequential single-precision subtractor:
// FSM encoding, field widths and special-value constants.
package fp_sub_seq_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned GRS_W = 3;
  localparam int unsigned DP_W  = 27;
  localparam int unsigned SUM_W = DP_W + 1;

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    ALIGN  = 3'd2,
    ADD    = 3'd3,
    NORM   = 3'd4,
    DONE   = 3'd5
  } state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

endpackage

// File: rtl/fp_sub_seq_split.sv
// Splits an IEEE-754 single word into sign, exponent and mantissa fields.
module fp_sub_seq_split
  import fp_sub_seq_pkg::*;
(
  input  logic [31:0]      op_i,
  output logic             sign_c_o,
  output logic [EXP_W-1:0] exp_c_o,
  output logic [MAN_W-1:0] man_c_o
);

  fp_t op_c;

  assign op_c     = op_i;
  assign sign_c_o = op_c.sign;
  assign exp_c_o  = op_c.exp;
  assign man_c_o  = op_c.man;

endmodule

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE-754 single subtractor (a - b), truncating, with flush-to-zero
// for exponent-0 inputs and a canonical NaN for any exponent-255 input.
module fp_sub_seq
  import fp_sub_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d, sub_q, sub_d;
  logic [EXP_W-1:0]   exp_q, exp_d, diff_q, diff_d;
  logic [DP_W-1:0]    mx_q, mx_d, my_q, my_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  fp_t                res_q, res_d;
  logic               done_q, busy_q;

  logic               sa_c, sb_c;
  logic [EXP_W-1:0]   ea_c, eb_c;
  logic [MAN_W-1:0]   ma_c, mb_c, fa_c, fb_c;
  logic [DP_W-1:0]    xa_c, xb_c;
  logic               a_ge_b_c;

  fp_sub_seq_split u_split_a (.op_i(a_q), .sign_c_o(sa_c), .exp_c_o(ea_c), .man_c_o(ma_c));
  fp_sub_seq_split u_split_b (.op_i(b_q), .sign_c_o(sb_c), .exp_c_o(eb_c), .man_c_o(mb_c));

  // Exponent-0 operands are flushed to zero, so they carry neither hidden bit nor fraction.
  assign fa_c     = (ea_c != '0) ? ma_c : '0;
  assign fb_c     = (eb_c != '0) ? mb_c : '0;
  assign xa_c     = {ea_c != '0, fa_c, GRS_W'(0)};
  assign xb_c     = {eb_c != '0, fb_c, GRS_W'(0)};
  assign a_ge_b_c = {ea_c, fa_c} >= {eb_c, fb_c};

  assign result = res_q;
  assign done   = done_q;
  assign busy   = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      diff_q  <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      sum_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      diff_q  <= diff_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      sum_q   <= sum_d;
      res_q   <= res_d;
      done_q  <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    diff_d  = diff_q;
    mx_d    = mx_q;
    my_d    = my_q;
    sum_d   = sum_q;
    res_d   = res_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = {~b[31], b[30:0]};
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        if (ea_c == EXP_INF || eb_c == EXP_INF) begin
          res_d   = QNAN;
          state_d = DONE;
        end else begin
          sub_d   = sa_c ^ sb_c;
          state_d = ALIGN;
          if (a_ge_b_c) begin
            sign_d = sa_c;
            exp_d  = ea_c;
            diff_d = ea_c - eb_c;
            mx_d   = xa_c;
            my_d   = xb_c;
          end else begin
            sign_d = sb_c;
            exp_d  = eb_c;
            diff_d = eb_c - ea_c;
            mx_d   = xb_c;
            my_d   = xa_c;
          end
        end
      end

      ALIGN: begin
        if (diff_q == '0) begin
          state_d = ADD;
        end else if (diff_q >= EXP_W'(DP_W)) begin
          my_d    = DP_W'(|my_q);
          diff_d  = '0;
          state_d = ADD;
        end else begin
          my_d   = {1'b0, my_q[DP_W-1:2], |my_q[1:0]};
          diff_d = diff_q - EXP_W'(1);
          if (diff_q == EXP_W'(1)) state_d = ADD;
        end
      end

      ADD: begin
        sum_d   = sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
        state_d = NORM;
      end

      // Normalise to a leading one at bit 26; GRS bits are dropped at pack.
      NORM: begin
        if (sum_q == '0) begin
          res_d   = '0;
          state_d = DONE;
        end else if (sum_q[SUM_W-1]) begin
          sum_d = {1'b0, sum_q[SUM_W-1:2], |sum_q[1:0]};
          exp_d = exp_q + EXP_W'(1);
          if (exp_q == EXP_INF - EXP_W'(1)) begin
            res_d   = {sign_q, EXP_INF, MAN_W'(0)};
            state_d = DONE;
          end
        end else if (sum_q[SUM_W-2]) begin
          res_d   = {sign_q, exp_q, sum_q[SUM_W-3:GRS_W]};
          state_d = DONE;
        end else begin
          sum_d = {sum_q[SUM_W-2:0], 1'b0};
          exp_d = exp_q - EXP_W'(1);
          if (exp_q == EXP_W'(1)) begin
            res_d   = {sign_q, 31'(0)};
            state_d = DONE;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// Randomised scoreboard bench for fp_sub_seq against an exact-arithmetic
// truncating reference model.
module tb_fp_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        done, busy;

  always #5 clk = ~clk;

  fp_sub_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .result(result), .done(done), .busy(busy)
  );

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          passed = 0;
  logic        prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
  endtask

  // Exact result of a + (-b) with flush-to-zero inputs, then truncated.
  function automatic logic [31:0] ref_sub(input logic [31:0] av, input logic [31:0] bv);
    logic [299:0] ia, ib, r;
    logic         sa, sb, sr;
    int           ea, eb, emin, p, e;
    logic [22:0]  m;
    ea = int'(av[30:23]);
    eb = int'(bv[30:23]);
    if (ea == 255 || eb == 255) return 32'h7FC0_0000;
    sa = av[31];
    sb = ~bv[31];
    ia = (ea == 0) ? '0 : 300'({1'b1, av[22:0]});
    ib = (eb == 0) ? '0 : 300'({1'b1, bv[22:0]});
    emin = (ea < eb) ? ea : eb;
    ia = ia << (ea - emin);
    ib = ib << (eb - emin);
    if (sa == sb)      begin r = ia + ib; sr = sa; end
    else if (ia >= ib) begin r = ia - ib; sr = sa; end
    else               begin r = ib - ia; sr = sb; end
    if (r == '0) return 32'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (r[i]) p = i;
    e = emin + p - 23;
    if (e >= 255) return {sr, 8'hFF, 23'h0};
    if (e <= 0)   return {sr, 31'h0};
    if (p >= 23) m = 23'(r >> (p - 23));
    else         m = 23'(r << (23 - p));
    return {sr, 8'(e), m};
  endfunction

  // Monitor: pop the scoreboard on every done pulse.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) prev_done = 1'b0;
      else begin
        if (done) begin
          chk("done_single_cycle", {31'h0, prev_done}, 32'h0);
          chk("busy_during_done", {31'h0, busy}, 32'h1);
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL spurious_done: got result %08h expected no done", result);
          end else begin
            e = exp_q.pop_front();
            chk("result", result, e);
          end
        end
        prev_done = done;
      end
    end
  end

  // Issue one subtraction; hold=1 keeps start asserted (with junk operands) through DONE.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input bit hold);
    int n;
    int lat;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) begin
      checks++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
    a = av; b = bv; start = 1'b1;
    exp_q.push_back(ref_sub(av, bv));
    @(negedge clk);
    lat = 1;
    a = $urandom; b = $urandom;
    if (!hold) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
    end
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (hold) begin a = $urandom; b = $urandom; end
    end
    if (!done) begin
      checks++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
    end else begin
      chk("latency_le_60", {31'h0, lat <= 60}, 32'h1);
    end
    if (hold) @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic s, input int e, input logic [22:0] m);
    int ec;
    ec = (e < 0) ? 0 : ((e > 255) ? 255 : e);
    return {s, 8'(ec), m};
  endfunction

  initial begin
    logic [31:0] av, bv;
    int mode, ea;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_result", result, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'h40A0_0000, 32'h4040_0000, 1'b0);
    issue(32'h4040_0000, 32'h4040_0000, 1'b0);
    issue(32'h3F80_0000, 32'h4000_0000, 1'b1);
    issue(32'h4B80_0000, 32'h3F80_0000, 1'b0);
    issue(32'h7F7F_FFFF, 32'hFF7F_FFFF, 1'b0);
    issue(32'h7F80_0000, 32'h1234_5678, 1'b1);
    issue(32'h3F80_0000, 32'hFF80_0000, 1'b0);
    issue(32'h8000_0000, 32'h0000_0000, 1'b0);
    issue(32'h0012_3456, 32'hC000_0000, 1'b0);
    issue(32'h5000_0000, 32'h3F80_0001, 1'b0);
    issue(32'h0080_0001, 32'h0080_0000, 1'b0);

    // Abandon a long-alignment operation with reset.
    @(negedge clk);
    a = 32'h4B80_0000; b = 32'h3F80_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midop_rst_result", result, 32'h0);
    chk("midop_rst_done", {31'h0, done}, 32'h0);
    chk("midop_rst_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(32'h4B80_0000, 32'h3F80_0000, 1'b0);

    for (int k = 0; k < 250; k++) begin
      mode = int'($urandom_range(0, 5));
      av = $urandom; bv = $urandom;
      ea = int'($urandom_range(1, 254));
      case (mode)
        1: begin
          av = mk(av[31], ea, av[22:0]);
          bv = mk(bv[31], ea + int'($urandom_range(0, 60)) - 30, bv[22:0]);
        end
        2: bv = av ^ {1'b0, 29'h0, 2'($urandom_range(0, 3))} ^ {1'($urandom_range(0, 1)), 31'h0};
        3: begin
          av = mk(av[31], int'($urandom_range(0, 4)), av[22:0]);
          bv = mk(bv[31], int'($urandom_range(0, 4)), bv[22:0]);
        end
        4: begin
          av = mk(av[31], int'($urandom_range(250, 254)), av[22:0]);
          bv = mk(bv[31], int'($urandom_range(250, 254)), bv[22:0]);
        end
        5: begin
          if ($urandom_range(0, 1) == 1) av = mk(av[31], ($urandom_range(0, 1) == 1) ? 255 : 0, av[22:0]);
          else                           bv = mk(bv[31], ($urandom_range(0, 1) == 1) ? 255 : 0, bv[22:0]);
        end
        default: ;
      endcase
      issue(av, bv, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
